// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter slice.
//   ARB_REQ_NUM  : number of requesters
//   ARB_ID_WIDTH : width of a requester index
//   arb_state_e  : burst-lock state (used when ARB_RR_4TO1_LOCK_EN is defined)
//   arb_rr_pick  : rotating-priority search starting at a pointer
// ----------------------------------------------------------------------------
package arb_pkg;

   localparam int unsigned ARB_REQ_NUM  = 4;
   localparam int unsigned ARB_ID_WIDTH = 2;

   typedef enum logic [0:0] {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   typedef struct packed {
      logic                    found;
      logic [ARB_ID_WIDTH-1:0] idx;
   } arb_pick_t;

   // First set bit of req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // Walks the offsets from last to first so the nearest hit overwrites.
   function automatic arb_pick_t arb_rr_pick(input logic [ARB_REQ_NUM-1:0]  req,
                                             input logic [ARB_ID_WIDTH-1:0] ptr);
      arb_pick_t               pick;
      logic [ARB_ID_WIDTH-1:0] idx;
      pick.found = 1'b0;
      pick.idx   = ptr;
      for (int i = ARB_REQ_NUM - 1; i >= 0; i--) begin
         idx = ptr + ARB_ID_WIDTH'(i);
         if (req[idx]) begin
            pick.found = 1'b1;
            pick.idx   = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mux_4to1.sv
// ----------------------------------------------------------------------------
// mux_4to1
// Four-way payload selector keyed by a requester index.
//   sel_i  : index of the selected input
//   data_i : four packed input words
//   data_o : selected word
// ----------------------------------------------------------------------------
module mux_4to1
   import arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [ARB_ID_WIDTH-1:0]                 sel_i,
   input  logic [ARB_REQ_NUM-1:0][DATA_WIDTH-1:0]  data_i,
   output logic [DATA_WIDTH-1:0]                   data_o
);

   always_comb begin
      data_o = data_i[sel_i];
   end

endmodule

// File: rtl/arb_rr_4to1.sv
// ----------------------------------------------------------------------------
// arb_rr_4to1
// Four-requester round-robin arbiter feeding a one-entry registered output
// stage. The winner's payload is picked by a mux_4to1 keyed by the grant.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req_valid    : per-requester valid
//   i_req_data     : per-requester payload
//   o_req_ready    : per-requester ready, one-hot or zero
//   i_req_last     : per-requester last-beat flag (ARB_RR_4TO1_LOCK_EN only)
//   o_out_valid    : output stage holds a beat
//   o_out_data     : registered winning payload
//   o_out_id       : index of the requester that produced o_out_data
//   o_out_last     : registered last flag (ARB_RR_4TO1_LOCK_EN only)
//   i_out_ready    : downstream accept
// Build option: define ARB_RR_4TO1_LOCK_EN to hold the grant on one requester
// until it presents a beat with last set.
// ----------------------------------------------------------------------------
module arb_rr_4to1
   import arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst_n,
   input  logic [ARB_REQ_NUM-1:0]                  i_req_valid,
   input  logic [ARB_REQ_NUM-1:0][DATA_WIDTH-1:0]  i_req_data,
   output logic [ARB_REQ_NUM-1:0]                  o_req_ready,
`ifdef ARB_RR_4TO1_LOCK_EN
   input  logic [ARB_REQ_NUM-1:0]                  i_req_last,
   output logic                                    o_out_last,
`endif
   output logic                                    o_out_valid,
   output logic [DATA_WIDTH-1:0]                   o_out_data,
   output logic [ARB_ID_WIDTH-1:0]                 o_out_id,
   input  logic                                    i_out_ready
);

   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic [ARB_ID_WIDTH-1:0] out_id_q, out_id_d;
   logic [ARB_ID_WIDTH-1:0] ptr_q, ptr_d;

   logic [ARB_REQ_NUM-1:0]  eligible;
   arb_pick_t               pick;
   logic                    slot_free;
   logic                    handshake;
   logic [DATA_WIDTH-1:0]   mux_data;

   mux_4to1 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux_data (
      .sel_i  (pick.idx),
      .data_i (i_req_data),
      .data_o (mux_data)
   );

`ifdef ARB_RR_4TO1_LOCK_EN
   arb_state_e              state_q, state_d;
   logic [ARB_ID_WIDTH-1:0] owner_q, owner_d;
   logic                    out_last_q, out_last_d;
   logic [ARB_REQ_NUM-1:0][0:0] req_last_arr;
   logic                    mux_last;

   assign req_last_arr = i_req_last;

   mux_4to1 #(
      .DATA_WIDTH (1)
   ) u_mux_last (
      .sel_i  (pick.idx),
      .data_i (req_last_arr),
      .data_o (mux_last)
   );

   // While locked only the owner can win; everyone else is masked off.
   always_comb begin
      eligible = i_req_valid;
      if (state_q == ARB_LOCKED) begin
         eligible = i_req_valid & (ARB_REQ_NUM'(1) << owner_q);
      end
   end
`else
   always_comb begin
      eligible = i_req_valid;
   end
`endif

   always_comb begin
      pick        = arb_rr_pick(eligible, ptr_q);
      slot_free   = !out_valid_q || i_out_ready;
      handshake   = i_rst_n && slot_free && pick.found;
      o_req_ready = handshake ? (ARB_REQ_NUM'(1) << pick.idx) : '0;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
`ifdef ARB_RR_4TO1_LOCK_EN
      state_d     = state_q;
      owner_d     = owner_q;
      out_last_d  = out_last_q;
`endif

      if (handshake) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
         out_id_d    = pick.idx;
`ifdef ARB_RR_4TO1_LOCK_EN
         out_last_d  = mux_last;
         owner_d     = pick.idx;
         // A non-last beat opens or continues a burst; the pointer only moves
         // once the burst closes so the next search starts past the owner.
         if (mux_last) begin
            state_d = ARB_IDLE;
            ptr_d   = pick.idx + ARB_ID_WIDTH'(1);
         end else begin
            state_d = ARB_LOCKED;
         end
`else
         ptr_d       = pick.idx + ARB_ID_WIDTH'(1);
`endif
      end else if (slot_free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
`ifdef ARB_RR_4TO1_LOCK_EN
         state_q     <= ARB_IDLE;
         owner_q     <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
`ifdef ARB_RR_4TO1_LOCK_EN
         state_q     <= state_d;
         owner_q     <= owner_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_out_data  = out_data_q;
   assign o_out_id    = out_id_q;
`ifdef ARB_RR_4TO1_LOCK_EN
   assign o_out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_arb_rr_4to1.sv
// ----------------------------------------------------------------------------
// tb_arb_rr_4to1
// Self-checking bench for arb_rr_4to1. Each step drives one cycle of inputs
// with a hand-derived expected o_req_ready; granted beats are pushed to a
// scoreboard queue and compared against o_out_* while they sit in the
// output stage. Lock sequences run when ARB_RR_4TO1_LOCK_EN is defined.
// ----------------------------------------------------------------------------
module tb_arb_rr_4to1;

   localparam int unsigned DW = 32;

   typedef struct {
      logic       rst_n;
      logic [3:0] valid;
      logic       out_ready;
      logic [3:0] exp_ready;
   } vec_t;

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic                 clk;
   logic                 rst_n_drv;
   logic [3:0]           req_valid;
   logic [3:0][DW-1:0]   req_data;
   logic [3:0]           req_last;
   logic [3:0]           o_req_ready;
   logic                 o_out_valid;
   logic [DW-1:0]        o_out_data;
   logic [1:0]           o_out_id;
   logic                 o_out_last_w;
   logic                 out_ready_drv;

   int    n_vec  = 0;
   int    n_miss = 0;
   beat_t sb[$];
   vec_t  tbl[$];
   logic  after_rst = 1'b1;

   arb_rr_4to1 #(
      .DATA_WIDTH (DW)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n_drv),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (o_req_ready),
`ifdef ARB_RR_4TO1_LOCK_EN
      .i_req_last  (req_last),
      .o_out_last  (o_out_last_w),
`endif
      .o_out_valid (o_out_valid),
      .o_out_data  (o_out_data),
      .o_out_id    (o_out_id),
      .i_out_ready (out_ready_drv)
   );

`ifndef ARB_RR_4TO1_LOCK_EN
   assign o_out_last_w = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) r = 2'(i);
      end
      return r;
   endfunction

   // One cycle: drive on the falling edge, check 1 time unit later, then
   // update the scoreboard for what the next rising edge will do.
   task automatic step(input logic rst_n, input logic [3:0] valid, input logic out_ready,
                       input logic [3:0] exp_ready, input string name);
      beat_t      b;
      logic       exp_valid;
      logic [1:0] g;
      @(negedge clk);
      rst_n_drv     = rst_n;
      req_valid     = valid;
      out_ready_drv = out_ready;
      #1;
      exp_valid = (sb.size() != 0);
      chk({name, " out_valid"}, DW'(o_out_valid), DW'(exp_valid));
      if (exp_valid) begin
         chk({name, " out_id"}, DW'(o_out_id), DW'(sb[0].id));
         chk({name, " out_data"}, o_out_data, sb[0].data);
`ifdef ARB_RR_4TO1_LOCK_EN
         chk({name, " out_last"}, DW'(o_out_last_w), DW'(sb[0].last));
`endif
      end
      if (after_rst) begin
         chk({name, " rst out_id"}, DW'(o_out_id), '0);
         chk({name, " rst out_data"}, o_out_data, '0);
         chk({name, " rst out_last"}, DW'(o_out_last_w), '0);
      end
      chk({name, " req_ready"}, DW'(o_req_ready), DW'(exp_ready));
      if (rst_n) begin
         if (exp_valid && out_ready) void'(sb.pop_front());
         if (exp_ready != 4'h0) begin
            g      = oh_idx(exp_ready);
            b.id   = g;
            b.data = req_data[g];
            b.last = req_last[g];
            sb.push_back(b);
         end
         after_rst = 1'b0;
      end else begin
         sb.delete();
         after_rst = 1'b1;
      end
   endtask

   initial begin
      rst_n_drv     = 1'b0;
      req_valid     = 4'hF;
      out_ready_drv = 1'b1;
      req_last      = 4'hF;
      for (int k = 0; k < 4; k++) req_data[k] = DW'(32'hA0 + k);

      // rst_n, valid, out_ready, expected o_req_ready
      for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, 1'b1, 4'h0});
      for (int i = 0; i < 2; i++) begin
         tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h1});
         tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h2});
         tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h4});
         tbl.push_back('{1'b1, 4'hF, 1'b1, 4'h8});
      end
      tbl.push_back('{1'b1, 4'h8, 1'b1, 4'h8});  // sparse: only 3, ptr wraps to 0
      tbl.push_back('{1'b1, 4'h3, 1'b1, 4'h1});
      tbl.push_back('{1'b1, 4'h3, 1'b1, 4'h2});
      tbl.push_back('{1'b1, 4'h0, 1'b1, 4'h0});  // drain to empty
      tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0});  // empty slot is free even if not ready
      tbl.push_back('{1'b1, 4'h1, 1'b0, 4'h1});  // ptr=2, search wraps to 0
      tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 4'h0, 1'b1, 4'h0});

      foreach (tbl[i]) begin
         step(tbl[i].rst_n, tbl[i].valid, tbl[i].out_ready, tbl[i].exp_ready,
              $sformatf("tbl[%0d]", i));
      end

      // Backpressure: 0x55 from requester 2 held for 4 stalled cycles.
      req_data[2] = DW'(32'h55);
      step(1'b1, 4'h4, 1'b1, 4'h4, "bp load");
      for (int i = 0; i < 4; i++) step(1'b1, 4'hF, 1'b0, 4'h0, $sformatf("bp stall%0d", i));
      step(1'b1, 4'hF, 1'b1, 4'h8, "bp drain+refill");
      step(1'b1, 4'h0, 1'b1, 4'h0, "bp drain");
      req_data[2] = DW'(32'hA2);

      // Reset while a beat sits in the output stage.
      step(1'b1, 4'h2, 1'b1, 4'h2, "mid load");
      step(1'b0, 4'hF, 1'b0, 4'h0, "mid reset");
      step(1'b1, 4'hF, 1'b1, 4'h1, "mid first grant");
      step(1'b1, 4'h0, 1'b1, 4'h0, "mid drain");

`ifdef ARB_RR_4TO1_LOCK_EN
      // Requester 1 bursts 3 beats while 0 and 2 also request.
      req_last = 4'h0;
      step(1'b1, 4'h7, 1'b1, 4'h2, "lock b0");
      step(1'b1, 4'h7, 1'b1, 4'h2, "lock b1");
      req_last = 4'h2;
      step(1'b1, 4'h7, 1'b1, 4'h2, "lock b2");
      req_last = 4'hF;
      step(1'b1, 4'h5, 1'b1, 4'h4, "lock after2");
      step(1'b1, 4'h1, 1'b1, 4'h1, "lock after0");
      // Reset while locked on owner 1.
      req_last = 4'h0;
      step(1'b1, 4'h2, 1'b1, 4'h2, "rlock open");
      step(1'b0, 4'hF, 1'b1, 4'h0, "rlock reset");
      req_last = 4'hF;
      step(1'b1, 4'hF, 1'b1, 4'h1, "rlock grant0");
      step(1'b1, 4'hF, 1'b1, 4'h2, "rlock grant1");
      step(1'b1, 4'h0, 1'b1, 4'h0, "rlock drain");
`endif

      step(1'b1, 4'h0, 1'b1, 4'h0, "final idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
